// File: rtl/c_bus_writeback.sv
// C-bus write-back stage: a one-entry write buffer commits ALU results into R1-R4, R, PC, MAR and MDR.
// Commits to MAR/MDR stall while memory owns them. Register outputs show committed state only.
module c_bus_writeback #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned PC_W   = 9,
  parameter int unsigned MEM_W  = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] C_bus,
  input  logic [3:0]        c_control,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              mem_busy,
  input  logic              pc_inc,
  input  logic              clr_err,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R,
  output logic [PC_W-1:0]   PC,
  output logic [PC_W-1:0]   MAR,
  output logic [MEM_W-1:0]  MDR,
  output logic              wr_done,
  output logic              trunc_err
);

  localparam logic [3:0] CODE_MDR = 4'd1;
  localparam logic [3:0] CODE_PC  = 4'd2;
  localparam logic [3:0] CODE_MAR = 4'd3;
  localparam logic [3:0] CODE_R1  = 4'd4;
  localparam logic [3:0] CODE_R2  = 4'd5;
  localparam logic [3:0] CODE_R3  = 4'd6;
  localparam logic [3:0] CODE_R4  = 4'd7;
  localparam logic [3:0] CODE_R   = 4'd8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        code;
  } wb_entry_t;

  logic      r_buf_valid;
  wb_entry_t r_buf;

  logic w_mem_dest;
  logic w_blocked;
  logic w_commit;
  logic w_accept;
  logic w_pc_hi_nz;
  logic w_mdr_hi_nz;
  logic w_trunc;

  // A buffered MAR/MDR write cannot retire while memory is using those registers.
  always_comb begin
    w_mem_dest  = (r_buf.code == CODE_MDR) || (r_buf.code == CODE_MAR);
    w_blocked   = r_buf_valid && mem_busy && w_mem_dest;
    w_commit    = r_buf_valid && !w_blocked;
    c_ready     = !r_buf_valid || !w_blocked;
    w_accept    = c_valid && c_ready;
    w_pc_hi_nz  = |r_buf.data[DATA_W-1:PC_W];
    w_mdr_hi_nz = |r_buf.data[DATA_W-1:MEM_W];
    w_trunc     = 1'b0;
    if (w_commit) begin
      case (r_buf.code)
        CODE_PC, CODE_MAR: w_trunc = w_pc_hi_nz;
        CODE_MDR:          w_trunc = w_mdr_hi_nz;
        default:           w_trunc = 1'b0;
      endcase
    end
  end

  // Write buffer: refill on accept, drain on commit, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
      r_buf       <= '{data: C_bus, code: c_control};
    end else if (w_commit) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Architectural registers; a PC commit overrides a same-edge increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R1        <= '0;
      R2        <= '0;
      R3        <= '0;
      R4        <= '0;
      R         <= '0;
      PC        <= PC_RESET;
      MAR       <= '0;
      MDR       <= '0;
      wr_done   <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      wr_done <= w_commit;
      if (w_trunc) begin
        trunc_err <= 1'b1;
      end else if (clr_err) begin
        trunc_err <= 1'b0;
      end
      if (w_commit && (r_buf.code == CODE_PC)) begin
        PC <= r_buf.data[PC_W-1:0];
      end else if (pc_inc) begin
        PC <= PC + PC_W'(1);
      end
      if (w_commit) begin
        case (r_buf.code)
          CODE_MDR: MDR <= r_buf.data[MEM_W-1:0];
          CODE_MAR: MAR <= r_buf.data[PC_W-1:0];
          CODE_R1:  R1  <= r_buf.data;
          CODE_R2:  R2  <= r_buf.data;
          CODE_R3:  R3  <= r_buf.data;
          CODE_R4:  R4  <= r_buf.data;
          CODE_R:   R   <= r_buf.data;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c_bus_writeback.sv
// Directed bench for c_bus_writeback: hand-computed expectations for reset, streaming, stalls,
// PC behaviour, truncation and mid-operation reset.
module tb_c_bus_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] C_bus;
  logic [3:0]  c_control;
  logic        c_valid;
  logic        c_ready;
  logic        mem_busy;
  logic        pc_inc;
  logic        clr_err;
  logic [23:0] R1, R2, R3, R4, R;
  logic [8:0]  PC, MAR;
  logic [7:0]  MDR;
  logic        wr_done;
  logic        trunc_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  c_bus_writeback #(.DATA_W(24), .PC_W(9), .MEM_W(8), .PC_RESET(9'h000)) dut (
    .clk(clk), .rst_n(rst_n), .C_bus(C_bus), .c_control(c_control), .c_valid(c_valid),
    .c_ready(c_ready), .mem_busy(mem_busy), .pc_inc(pc_inc), .clr_err(clr_err),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R(R), .PC(PC), .MAR(MAR), .MDR(MDR),
    .wr_done(wr_done), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] d, input logic [3:0] code);
    c_valid   = v;
    C_bus     = d;
    c_control = code;
  endtask

  initial begin
    rst_n = 1'b0; mem_busy = 1'b0; pc_inc = 1'b0; clr_err = 1'b0;
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("rst_R1", 32'(R1), 32'h0);
    check("rst_R2", 32'(R2), 32'h0);
    check("rst_R3", 32'(R3), 32'h0);
    check("rst_R4", 32'(R4), 32'h0);
    check("rst_R", 32'(R), 32'h0);
    check("rst_PC", 32'(PC), 32'h0);
    check("rst_MAR", 32'(MAR), 32'h0);
    check("rst_MDR", 32'(MDR), 32'h0);
    check("rst_ready", 32'(c_ready), 32'h1);
    check("rst_wr_done", 32'(wr_done), 32'h0);
    check("rst_trunc", 32'(trunc_err), 32'h0);
    rst_n = 1'b1;

    // Back-to-back stream
    drive(1'b1, 24'h123456, 4'd4);
    check("b2b_ready0", 32'(c_ready), 32'h1);
    tick();
    check("b2b_R1_nobypass", 32'(R1), 32'h0);
    check("b2b_wd0", 32'(wr_done), 32'h0);
    drive(1'b1, 24'hABCDEF, 4'd8);
    check("b2b_ready1", 32'(c_ready), 32'h1);
    tick();
    check("b2b_R1", 32'(R1), 32'h123456);
    check("b2b_wd1", 32'(wr_done), 32'h1);
    drive(1'b1, 24'h000055, 4'd1);
    check("b2b_ready2", 32'(c_ready), 32'h1);
    tick();
    check("b2b_R", 32'(R), 32'hABCDEF);
    check("b2b_wd2", 32'(wr_done), 32'h1);
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("b2b_MDR", 32'(MDR), 32'h55);
    check("b2b_wd3", 32'(wr_done), 32'h1);
    check("b2b_trunc", 32'(trunc_err), 32'h0);
    tick();
    check("b2b_wd_end", 32'(wr_done), 32'h0);

    // Stall on MDR while memory is busy
    mem_busy = 1'b1;
    drive(1'b1, 24'h0000AA, 4'd1);
    check("stl_ready_empty", 32'(c_ready), 32'h1);
    tick();
    check("stl_ready_blk", 32'(c_ready), 32'h0);
    drive(1'b1, 24'h000001, 4'd5);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stl_MDR_hold", 32'(MDR), 32'h55);
      check("stl_R2_hold", 32'(R2), 32'h0);
      check("stl_ready_hold", 32'(c_ready), 32'h0);
      check("stl_wd_hold", 32'(wr_done), 32'h0);
    end
    mem_busy = 1'b0;
    #1;
    check("stl_ready_rel", 32'(c_ready), 32'h1);
    tick();
    check("stl_MDR", 32'(MDR), 32'hAA);
    check("stl_R2_order", 32'(R2), 32'h0);
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("stl_R2", 32'(R2), 32'h1);

    // PC load, wrap and commit-beats-increment
    drive(1'b1, 24'h0001FF, 4'd2);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("pc_load", 32'(PC), 32'h1FF);
    pc_inc = 1'b1;
    tick();
    check("pc_wrap", 32'(PC), 32'h000);
    pc_inc = 1'b0;
    drive(1'b1, 24'h000010, 4'd2);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("pc_commit_wins", 32'(PC), 32'h010);
    check("pc_trunc", 32'(trunc_err), 32'h0);

    // Truncation to MAR, clear, then set-vs-clear on MDR
    drive(1'b1, 24'h000300, 4'd3);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("tr_MAR", 32'(MAR), 32'h100);
    check("tr_set", 32'(trunc_err), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tr_clr", 32'(trunc_err), 32'h0);
    drive(1'b1, 24'h000123, 4'd1);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tr_MDR", 32'(MDR), 32'h23);
    check("tr_set_wins", 32'(trunc_err), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // No-op code still pulses wr_done and changes nothing
    drive(1'b1, 24'hFFFFFF, 4'd0);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    tick();
    check("nop_wd", 32'(wr_done), 32'h1);
    check("nop_R1", 32'(R1), 32'h123456);
    check("nop_trunc", 32'(trunc_err), 32'h0);

    // Reset on the commit edge discards the buffered write
    drive(1'b1, 24'h777777, 4'd6);
    tick();
    drive(1'b0, 24'h0, 4'd0);
    rst_n = 1'b0;
    tick();
    check("mr_R3", 32'(R3), 32'h0);
    check("mr_R1", 32'(R1), 32'h0);
    check("mr_PC", 32'(PC), 32'h0);
    check("mr_wd", 32'(wr_done), 32'h0);
    check("mr_ready", 32'(c_ready), 32'h1);
    rst_n = 1'b1;
    tick();
    check("mr_R3_after", 32'(R3), 32'h0);
    check("mr_wd_after", 32'(wr_done), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
